// File: rtl/exponent_request_sequencer.sv
// Initiator side of the exponent-finder handshake: runs the finder once per accepted
// prime base and emits (base, exponent) pairs on a valid/ready stream.
module exponent_request_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int GAP     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] boundary,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  in_base,
   output logic        find_enable,
   output logic [63:0] find_boundary,
   output logic [8:0]  find_base,
   input  logic        find_ready,
   input  logic [7:0]  find_exponent,
   output logic        pair_valid,
   input  logic        pair_ready,
   output logic [8:0]  pair_base,
   output logic [7:0]  pair_exponent,
   output logic        pair_error,
   output logic [15:0] pair_count,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT,
      ST_DRAIN,
      ST_EMIT
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [TW-1:0]   timer;
   logic [GW-1:0]   gap_cnt;
   logic            accept;
   logic            capture;
   logic            timeout;
   logic            base_illegal;

   assign base_illegal = (in_base < 9'd2);
   assign in_ready     = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign pair_valid   = (state == ST_EMIT);
   assign pair_base    = find_base;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ARM deliberately ignores find_ready: it may still be high from the previous run.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = base_illegal ? ST_EMIT : ST_ARM;
            end
         end
         ST_ARM: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (find_ready) begin
               capture    = 1'b1;
               state_next = ST_DRAIN;
            end else if (timer == TIMER_LAST) begin
               timeout    = 1'b1;
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (gap_cnt == GAP_LAST) begin
               state_next = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (pair_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         find_enable   <= 1'b0;
         find_base     <= '0;
         find_boundary <= '0;
         pair_exponent <= '0;
         pair_error    <= 1'b0;
         timer         <= '0;
         gap_cnt       <= '0;
         pair_count    <= '0;
      end else begin
         find_enable <= (state_next == ST_ARM) || (state_next == ST_WAIT);
         if (accept) begin
            find_base     <= in_base;
            find_boundary <= boundary;
            pair_exponent <= '0;
            pair_error    <= base_illegal;
            timer         <= '0;
         end
         if (state == ST_WAIT) begin
            timer <= timer + TW'(1);
         end
         if (capture) begin
            pair_exponent <= find_exponent;
         end
         if (timeout) begin
            pair_exponent <= '0;
            pair_error    <= 1'b1;
         end
         gap_cnt <= (state == ST_DRAIN) ? gap_cnt + GW'(1) : '0;
         if ((state == ST_EMIT) && pair_ready) begin
            pair_count <= pair_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/exponent_request_sequencer.md
Name: exponent_request_sequencer

Overview:
- Initiator side of the exponent-finder handshake for the Pollard p-1 datapath.
- Accepts a stream of prime bases and drives one finder run per base: it raises the finder enable, waits for the finder's ready, and captures the finder's exponent.
- Emits each (base, exponent) pair on a valid/ready output stream for the modular-exponentiation stage.
- Guards the finder against illegal bases and hung runs.

Parameters:
- TIMEOUT, 64, maximum cycles in WAIT before the run is aborted with error.
- GAP, 2, cycles find_enable is held low after each run so the finder returns to its idle product.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- boundary  input  64  smoothness bound B, sampled at base accept
- in_valid  input  1  in_base is valid
- in_ready  output  1  sequencer can accept a base
- in_base  input  9  prime base q
- find_enable  output  1  to finder input_enable
- find_boundary  output  64  to finder boundary, latched copy
- find_base  output  9  to finder base, latched copy
- find_ready  input  1  from finder ready
- find_exponent  input  8  from finder exponent
- pair_valid  output  1  output pair valid
- pair_ready  input  1  downstream accepts pair
- pair_base  output  9  base of emitted pair
- pair_exponent  output  8  exponent of emitted pair
- pair_error  output  1  pair invalid: base<2 or timeout
- pair_count  output  16  number of pairs accepted downstream, wraps at 65535->0
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, any state) -> IDLE. All outputs 0 except in_ready=1: find_enable, pair_valid, pair_error, pair_count, find_base, find_boundary, pair_exponent and busy are 0.
- States: IDLE, ARM, WAIT, DRAIN, EMIT. in_ready = (state==IDLE) only.
- IDLE:
  - On in_valid & in_ready, latch in_base into find_base/pair_base and boundary into find_boundary.
  - If in_base < 2: pair_exponent=0, pair_error=1 -> EMIT. The finder is never enabled.
  - Otherwise: pair_error=0, timer=0 -> ARM.
- ARM, one cycle:
  - find_enable=1; find_ready is ignored, because the finder's ready can still be high from the previous run.
  - -> WAIT.
- WAIT:
  - find_enable=1; timer increments each cycle.
  - If find_ready=1: capture find_exponent into pair_exponent -> DRAIN. Ready wins over a same-cycle timeout.
  - Else if timer==TIMEOUT-1: pair_exponent=0, pair_error=1 -> DRAIN.
- DRAIN:
  - find_enable=0 for exactly GAP cycles (gap counter), then -> EMIT.
  - find_ready/find_exponent changes during DRAIN are ignored.
- EMIT:
  - pair_valid=1; pair_* held stable until pair_ready.
  - On pair_valid & pair_ready: pair_count+1, pair_valid=0 next cycle -> IDLE.
  - No new base is accepted in the handshake cycle. Minimum one IDLE cycle between pairs.
- find_enable is registered (no combinational path from any input). It is high exactly during ARM and WAIT.
- Latency, legal base: 1 (ARM) + finder cycles observed in WAIT + GAP, then pair_valid.
- Latency, base<2: pair_valid on the cycle after accept.
- Boundary input may change freely after accept; the run uses the latched copy.
- The exponent is passed through unmodified (the finder's smallest e with q^e >= B). No arithmetic is performed here.

Test Plan:
- Reset mid-WAIT with find_enable=1: assert rst -> find_enable, pair_valid, busy=0 immediately (async); in_ready=1 after release; pair_count=0.
- Single run, behavioural finder model: boundary=100, base=3 -> exactly one pair {3, 5, err=0}; find_enable high in ARM+WAIT only, low ≥2 cycles after; pair_count=1. Repeat with base=2 -> {2, 7, 0}.
- Stale ready: finder ready held high from the previous run, next base=5, boundary=30. ARM must ignore it -> exponent 3, not the stale value.
- Illegal bases 0 and 1 -> pairs {0,0,1} and {1,0,1}, each one cycle after accept; find_enable never asserted.
- Timeout: finder model never asserts ready, TIMEOUT=64 -> pair_error=1 and exponent=0 after 64 WAIT cycles. Second check: ready arriving on the timeout cycle -> err=0 with the captured exponent.
- Backpressure and wrap: hold pair_ready=0 for 20 cycles -> pair stable, in_ready=0. Preload 65535 accepted pairs (or force pair_count=65535), then one more -> pair_count=0.
